// File: rtl/fma_sign_resolve.sv
// Final sign resolution for (a*b)+c: delay-matches the tentative sign from the sign
// handler to the mantissa adder flags and presents one registered sign per operation.
module fma_sign_resolve #(
  parameter int LAT   = 3,
  parameter int RND_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_s_tmp,
  input  logic             in_final_m,
  input  logic             add_valid,
  input  logic             add_neg,
  input  logic             add_zero,
  input  logic [RND_W-1:0] rnd_mode,
  output logic             out_valid,
  output logic             out_sign,
  output logic             align_err
);

  localparam logic [RND_W-1:0] RND_RDN = RND_W'(2'b11);

  // Exact-zero sum of opposite-signed terms is +0 except when rounding toward -inf.
  function automatic logic resolve_sign(
    input logic             s_tmp,
    input logic             final_m,
    input logic             neg,
    input logic             zero,
    input logic [RND_W-1:0] rnd
  );
    logic sign_v;
    if (final_m) begin
      sign_v = s_tmp;
    end else if (zero) begin
      sign_v = (rnd == RND_RDN) ? 1'b1 : 1'b0;
    end else begin
      sign_v = s_tmp ^ neg;
    end
    return sign_v;
  endfunction

  logic [LAT-1:0] v_r;
  logic [LAT-1:0] s_r;
  logic [LAT-1:0] m_r;
  logic           head_v_s;
  logic           resolve_s;
  logic           misalign_s;
  logic           sign_s;

  // Head-stage decode: resolve, misalignment and candidate sign.
  always_comb begin
    head_v_s   = v_r[LAT-1];
    resolve_s  = en & head_v_s & add_valid;
    misalign_s = en & (head_v_s ^ add_valid);
    sign_s     = resolve_sign(s_r[LAT-1], m_r[LAT-1], add_neg, add_zero, rnd_mode);
  end

  // Stage valid shift register; the head entry is consumed as it shifts out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= {LAT{1'b0}};
    end else if (flush) begin
      v_r <= {LAT{1'b0}};
    end else if (en) begin
      v_r[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        v_r[i] <= v_r[i-1];
      end
    end
  end

  // Sign/mask payload shift register, advancing in lockstep with the valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r <= {LAT{1'b0}};
      m_r <= {LAT{1'b0}};
    end else if (en) begin
      s_r[0] <= in_s_tmp;
      m_r[0] <= in_final_m;
      for (int i = 1; i < LAT; i++) begin
        s_r[i] <= s_r[i-1];
        m_r[i] <= m_r[i-1];
      end
    end
  end

  // Output register: pulse on resolve, sign holds between resolves and while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= resolve_s;
      if (resolve_s) begin
        out_sign <= sign_s;
      end
    end
  end

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (misalign_s) begin
      align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fma_sign_resolve.sv
// Directed self-checking bench for fma_sign_resolve with LAT=3.
module tb_fma_sign_resolve;

  logic       clk;
  logic       rst;
  logic       en;
  logic       flush;
  logic       in_valid;
  logic       in_s_tmp;
  logic       in_final_m;
  logic       add_valid;
  logic       add_neg;
  logic       add_zero;
  logic [1:0] rnd_mode;
  logic       out_valid;
  logic       out_sign;
  logic       align_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Stall table rows: {en, in_valid, s_tmp, final_m, add_valid, add_neg, exp_ov, exp_os}
  localparam logic [7:0] T5 [12] = '{
    8'b11110000, 8'b11010000, 8'b11110000, 8'b11111111,
    8'b00000011, 8'b00000011, 8'b11011010, 8'b11011111,
    8'b10001011, 8'b10001110, 8'b10001010, 8'b10000000
  };

  fma_sign_resolve #(.LAT(3), .RND_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_s_tmp   (in_s_tmp),
    .in_final_m (in_final_m),
    .add_valid  (add_valid),
    .add_neg    (add_neg),
    .add_zero   (add_zero),
    .rnd_mode   (rnd_mode),
    .out_valid  (out_valid),
    .out_sign   (out_sign),
    .align_err  (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_s_tmp = 1'b0; in_final_m = 1'b0;
    add_valid = 1'b0; add_neg = 1'b0; add_zero = 1'b0; rnd_mode = 2'b00;
  endtask

  // Issue one op, present its adder flags LAT cycles later, check the pulse and hold.
  task automatic run_op(input string tag, input logic s, input logic m, input logic neg,
                        input logic zero, input logic [1:0] rnd, input logic exp);
    in_valid = 1'b1; in_s_tmp = s; in_final_m = m;
    tick();
    check_eq({tag, "_early0"}, {7'd0, out_valid}, 8'd0);
    in_valid = 1'b0; in_s_tmp = 1'b0; in_final_m = 1'b0;
    tick();
    tick();
    check_eq({tag, "_early2"}, {7'd0, out_valid}, 8'd0);
    add_valid = 1'b1; add_neg = neg; add_zero = zero; rnd_mode = rnd;
    tick();
    check_eq({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    check_eq({tag, "_sign"}, {7'd0, out_sign}, {7'd0, exp});
    idle_inputs();
    tick();
    check_eq({tag, "_ov_end"}, {7'd0, out_valid}, 8'd0);
    check_eq({tag, "_sign_hold"}, {7'd0, out_sign}, {7'd0, exp});
    check_eq({tag, "_aerr"}, {7'd0, align_err}, 8'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_ov", {7'd0, out_valid}, 8'd0);
    check_eq("rst_os", {7'd0, out_sign}, 8'd0);
    check_eq("rst_aerr", {7'd0, align_err}, 8'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_ov", {7'd0, out_valid}, 8'd0);

    // Effective addition: sign is s_tmp, add_neg ignored
    run_op("final_m_neg", 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    // Effective subtraction: s_tmp ^ add_neg
    run_op("sub_neg1", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    run_op("sub_neg0", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    run_op("sub_s1_neg1", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    // Exact zero on subtraction depends on rounding mode
    run_op("zero_rdn", 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    run_op("zero_rne", 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    run_op("zero_rdn2", 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
    run_op("zero_rtz", 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    run_op("zero_rup", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    // Like-signed zeros keep their sign
    run_op("zero_like", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1);

    // Back-to-back issue with a two-cycle stall mid-stream
    for (int c = 0; c < 12; c++) begin
      en = T5[c][7]; in_valid = T5[c][6]; in_s_tmp = T5[c][5]; in_final_m = T5[c][4];
      add_valid = T5[c][3]; add_neg = T5[c][2];
      tick();
      check_eq($sformatf("stall_ov_c%0d", c), {7'd0, out_valid}, {7'd0, T5[c][1]});
      if (T5[c][1]) begin
        check_eq($sformatf("stall_os_c%0d", c), {7'd0, out_sign}, {7'd0, T5[c][0]});
      end
    end
    idle_inputs();
    check_eq("stall_aerr", {7'd0, align_err}, 8'd0);

    // Reset mid-stream: op A resolves while B, C, D are in flight
    in_valid = 1'b1; in_s_tmp = 1'b1; in_final_m = 1'b1;
    tick();
    tick();
    tick();
    add_valid = 1'b1;
    tick();
    check_eq("mid_ov_pre", {7'd0, out_valid}, 8'd1);
    check_eq("mid_os_pre", {7'd0, out_sign}, 8'd1);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ov", {7'd0, out_valid}, 8'd0);
    check_eq("mid_rst_os", {7'd0, out_sign}, 8'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq($sformatf("mid_stale_ov%0d", c), {7'd0, out_valid}, 8'd0);
      check_eq($sformatf("mid_stale_aerr%0d", c), {7'd0, align_err}, 8'd0);
    end

    // add_valid with empty pipe sets the sticky error
    add_valid = 1'b1;
    tick();
    check_eq("empty_av_aerr", {7'd0, align_err}, 8'd1);
    check_eq("empty_av_ov", {7'd0, out_valid}, 8'd0);
    add_valid = 1'b0;
    // Flush with two ops in flight and a third issuing in the flush cycle
    in_valid = 1'b1; in_s_tmp = 1'b1; in_final_m = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_ov", {7'd0, out_valid}, 8'd0);
    add_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("flushed_ov%0d", c), {7'd0, out_valid}, 8'd0);
    end
    idle_inputs();
    tick();
    check_eq("aerr_sticky", {7'd0, align_err}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
